// File: rtl/elastic_buffer_pkg.sv
// Shared types and default tuning constants for the elastic buffer read-side
// controller.
package elastic_buffer_pkg;

  // Read-side control states
  typedef enum logic [1:0] {
    FILL        = 2'd0,
    RUN         = 2'd1,
    INSERT_HOLD = 2'd2
  } eb_state_t;

  localparam int DEF_ADDRESS_WIDTH  = 4;
  localparam int DEF_HIGH_THRESHOLD = 12;
  localparam int DEF_LOW_THRESHOLD  = 4;
  localparam int DEF_COMP_GAP       = 8;

endpackage : elastic_buffer_pkg

// File: rtl/elastic_buffer_controller.sv
// Read-side controller of a clock-compensating elastic buffer. It tracks the
// fill level from the synchronized write pointer and delivers symbols on
// demand. It keeps the fill level centred by deleting or repeating SKP symbols.
// It recovers from underflow/overflow by re-centring the read pointer.
module elastic_buffer_controller
  import elastic_buffer_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int HIGH_THRESHOLD = DEF_HIGH_THRESHOLD,
  parameter int LOW_THRESHOLD  = DEF_LOW_THRESHOLD,
  parameter int COMP_GAP       = DEF_COMP_GAP
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDRESS_WIDTH:0] write_pointer_sync,
  input  logic                   read_request,
  input  logic                   read_data_is_skp,
  input  logic                   clear_errors,
  output logic [ADDRESS_WIDTH:0] read_pointer,
  output logic                   read_valid,
  output logic                   skp_inserted,
  output logic                   skp_deleted,
  output logic [ADDRESS_WIDTH:0] occupancy,
  output logic                   underflow,
  output logic                   overflow
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam int PTR_W = ADDRESS_WIDTH + 1;
  localparam int GAP_W = $clog2(COMP_GAP) + 1;

  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] HALF_P  = PTR_W'(DEPTH / 2);
  localparam logic [PTR_W-1:0] HIGH_P  = PTR_W'(HIGH_THRESHOLD);
  localparam logic [PTR_W-1:0] LOW_P   = PTR_W'(LOW_THRESHOLD);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(COMP_GAP);

  // Thresholds must straddle the half-full point so delete and insert can
  // never both qualify on the same symbol.
  if ((LOW_THRESHOLD >= DEPTH / 2) || (HIGH_THRESHOLD <= DEPTH / 2)) begin : g_bad_thresholds
    $error("elastic_buffer_controller: need LOW_THRESHOLD < DEPTH/2 < HIGH_THRESHOLD");
  end
  if (COMP_GAP < 1) begin : g_bad_gap
    $error("elastic_buffer_controller: COMP_GAP must be at least 1");
  end

  eb_state_t        state;
  eb_state_t        next_state;
  logic [PTR_W-1:0] rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             underflow_q;
  logic             overflow_q;

  logic             gap_ok;
  logic             rd_valid;
  logic             ins_pulse;
  logic             del_pulse;
  logic             ptr_adv;
  logic             gap_clr;
  logic             uf_evt;
  logic             of_evt;

  // Fill level is a plain modular difference; the wrap bit disambiguates
  // full from empty.
  assign occupancy    = write_pointer_sync - rd_ptr;
  assign read_pointer = rd_ptr;
  assign read_valid   = rd_valid;
  assign skp_inserted = ins_pulse;
  assign skp_deleted  = del_pulse;
  assign underflow    = underflow_q;
  assign overflow     = overflow_q;
  assign gap_ok       = (gap_cnt >= GAP_MAX);

  // Per-cycle decode of read, compensation and error events from state and
  // fill level. Overflow outranks everything because the read pointer must be
  // re-centred regardless of what the consumer is doing.
  always_comb begin
    next_state = state;
    rd_valid   = 1'b0;
    ins_pulse  = 1'b0;
    del_pulse  = 1'b0;
    ptr_adv    = 1'b0;
    gap_clr    = 1'b0;
    uf_evt     = 1'b0;
    of_evt     = 1'b0;
    if (occupancy == DEPTH_P) begin
      of_evt     = 1'b1;
      next_state = FILL;
    end else begin
      case (state)
        FILL: begin
          if (occupancy >= HALF_P) next_state = RUN;
        end
        RUN: begin
          if (read_request) begin
            if (occupancy == '0) begin
              uf_evt     = 1'b1;
              next_state = FILL;
            end else if (read_data_is_skp && (occupancy > HIGH_P) && gap_ok) begin
              // Drop the SKP: consume it without presenting it downstream.
              del_pulse = 1'b1;
              ptr_adv   = 1'b1;
              gap_clr   = 1'b1;
            end else if (read_data_is_skp && (occupancy < LOW_P) && gap_ok) begin
              // Repeat the SKP: present it now, re-read it next cycle.
              ins_pulse  = 1'b1;
              rd_valid   = 1'b1;
              gap_clr    = 1'b1;
              next_state = INSERT_HOLD;
            end else begin
              rd_valid = 1'b1;
              ptr_adv  = 1'b1;
            end
          end
        end
        INSERT_HOLD: begin
          if (read_request) begin
            if (occupancy == '0) begin
              uf_evt     = 1'b1;
              next_state = FILL;
            end else begin
              rd_valid   = 1'b1;
              ptr_adv    = 1'b1;
              next_state = RUN;
            end
          end
        end
        default: next_state = FILL;
      endcase
    end
  end

  // State, read pointer, compensation spacing counter and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      rd_ptr      <= '0;
      gap_cnt     <= GAP_MAX;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state <= next_state;

      if (of_evt)       rd_ptr <= write_pointer_sync - HALF_P;
      else if (ptr_adv) rd_ptr <= rd_ptr + PTR_W'(1);

      if (gap_clr)                gap_cnt <= '0;
      else if (gap_cnt < GAP_MAX) gap_cnt <= gap_cnt + GAP_W'(1);

      if (uf_evt)            underflow_q <= 1'b1;
      else if (clear_errors) underflow_q <= 1'b0;

      if (of_evt)            overflow_q <= 1'b1;
      else if (clear_errors) overflow_q <= 1'b0;
    end
  end

endmodule : elastic_buffer_controller

// File: tb/tb_elastic_buffer_controller.sv
// Directed bench for elastic_buffer_controller at ADDRESS_WIDTH=4, defaults.
module tb_elastic_buffer_controller;
  import elastic_buffer_pkg::*;

  logic       clock;
  logic       reset;
  logic [4:0] write_pointer_sync;
  logic       read_request;
  logic       read_data_is_skp;
  logic       clear_errors;
  logic [4:0] read_pointer;
  logic       read_valid;
  logic       skp_inserted;
  logic       skp_deleted;
  logic [4:0] occupancy;
  logic       underflow;
  logic       overflow;

  int checks;
  int errors;

  elastic_buffer_controller #(
    .ADDRESS_WIDTH (4),
    .HIGH_THRESHOLD(12),
    .LOW_THRESHOLD (4),
    .COMP_GAP      (8)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .write_pointer_sync(write_pointer_sync),
    .read_request      (read_request),
    .read_data_is_skp  (read_data_is_skp),
    .clear_errors      (clear_errors),
    .read_pointer      (read_pointer),
    .read_valid        (read_valid),
    .skp_inserted      (skp_inserted),
    .skp_deleted       (skp_deleted),
    .occupancy         (occupancy),
    .underflow         (underflow),
    .overflow          (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    write_pointer_sync = 5'd5;
    read_request = 1'b1;
    read_data_is_skp = 1'b1;
    clear_errors = 1'b0;
    tick();
    tick();
    checks++; if (read_pointer !== 5'd0) begin errors++; $display("FAIL reset_rp: got %0d expected 0", read_pointer); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", read_valid); end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got uf=%0b of=%0b expected 0/0", underflow, overflow); end
    checks++; if (occupancy !== 5'd5) begin errors++; $display("FAIL reset_occ: got %0d expected 5", occupancy); end
    checks++; if (skp_inserted !== 1'b0 || skp_deleted !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ins=%0b del=%0b expected 0/0", skp_inserted, skp_deleted); end
    write_pointer_sync = 5'd0;
    read_data_is_skp = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_fill_to_run();
    read_request = 1'b1;
    for (int w = 0; w < 8; w++) begin
      write_pointer_sync = 5'(w);
      #1;
      checks++; if (read_valid !== 1'b0 || read_pointer !== 5'd0) begin errors++; $display("FAIL fill_hold_w%0d: got valid=%0b rp=%0d expected 0/0", w, read_valid, read_pointer); end
      tick();
    end
    write_pointer_sync = 5'd8;
    #1;
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL fill_at8_valid: got %0b expected 0", read_valid); end
    tick();
    checks++; if (dut.state !== RUN) begin errors++; $display("FAIL fill_to_run_state: got %0d expected %0d", dut.state, RUN); end
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL run_first_valid: got %0b expected 1", read_valid); end
    tick();
    checks++; if (read_pointer !== 5'd1 || occupancy !== 5'd7) begin errors++; $display("FAIL run_first_adv: got rp=%0d occ=%0d expected 1/7", read_pointer, occupancy); end
    read_request = 1'b0;
    tick();
    checks++; if (read_pointer !== 5'd1 || read_valid !== 1'b0) begin errors++; $display("FAIL run_idle: got rp=%0d valid=%0b expected 1/0", read_pointer, read_valid); end
  endtask

  task automatic test_delete();
    // rp=1, write 14 -> occupancy 13, gap counter saturated
    write_pointer_sync = 5'd14;
    read_request = 1'b1;
    read_data_is_skp = 1'b1;
    #1;
    checks++; if (skp_deleted !== 1'b1 || read_valid !== 1'b0 || skp_inserted !== 1'b0) begin errors++; $display("FAIL delete_pulse: got del=%0b valid=%0b ins=%0b expected 1/0/0", skp_deleted, read_valid, skp_inserted); end
    tick();
    checks++; if (read_pointer !== 5'd2) begin errors++; $display("FAIL delete_adv: got rp=%0d expected 2", read_pointer); end
    write_pointer_sync = 5'd15;
    #1;
    checks++; if (occupancy !== 5'd13) begin errors++; $display("FAIL delete2_occ: got %0d expected 13", occupancy); end
    checks++; if (skp_deleted !== 1'b0 || read_valid !== 1'b1) begin errors++; $display("FAIL delete_gap_block: got del=%0b valid=%0b expected 0/1", skp_deleted, read_valid); end
    tick();
    checks++; if (read_pointer !== 5'd3) begin errors++; $display("FAIL delete_gap_adv: got rp=%0d expected 3", read_pointer); end
    read_data_is_skp = 1'b0;
  endtask

  task automatic test_insert();
    // nine plain reads: rp 3 -> 12, occupancy 12 -> 3, gap counter recovers
    read_request = 1'b1;
    read_data_is_skp = 1'b0;
    repeat (9) tick();
    checks++; if (read_pointer !== 5'd12 || occupancy !== 5'd3) begin errors++; $display("FAIL insert_setup: got rp=%0d occ=%0d expected 12/3", read_pointer, occupancy); end
    read_data_is_skp = 1'b1;
    #1;
    checks++; if (skp_inserted !== 1'b1 || read_valid !== 1'b1 || skp_deleted !== 1'b0) begin errors++; $display("FAIL insert_pulse: got ins=%0b valid=%0b del=%0b expected 1/1/0", skp_inserted, read_valid, skp_deleted); end
    tick();
    checks++; if (read_pointer !== 5'd12) begin errors++; $display("FAIL insert_hold_rp: got %0d expected 12", read_pointer); end
    checks++; if (dut.state !== INSERT_HOLD) begin errors++; $display("FAIL insert_hold_state: got %0d expected %0d", dut.state, INSERT_HOLD); end
    checks++; if (skp_inserted !== 1'b0 || read_valid !== 1'b1) begin errors++; $display("FAIL insert_no_repeat: got ins=%0b valid=%0b expected 0/1", skp_inserted, read_valid); end
    tick();
    checks++; if (read_pointer !== 5'd13 || dut.state !== RUN) begin errors++; $display("FAIL insert_release: got rp=%0d state=%0d expected 13/%0d", read_pointer, dut.state, RUN); end
    read_data_is_skp = 1'b0;
  endtask

  task automatic test_wrap();
    read_request = 1'b1;
    for (int i = 0; i < 17; i++) begin
      write_pointer_sync = 5'((13 + i + 8) % 32);
      tick();
    end
    checks++; if (read_pointer !== 5'd30) begin errors++; $display("FAIL wrap_setup: got rp=%0d expected 30", read_pointer); end
    write_pointer_sync = 5'd2;
    #1;
    checks++; if (occupancy !== 5'd4) begin errors++; $display("FAIL wrap_occ_w2_r30: got %0d expected 4", occupancy); end
    tick();
    checks++; if (read_pointer !== 5'd31 || occupancy !== 5'd3) begin errors++; $display("FAIL wrap_rp31: got rp=%0d occ=%0d expected 31/3", read_pointer, occupancy); end
    checks++; if (read_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %0b expected 1", read_valid); end
    tick();
    checks++; if (read_pointer !== 5'd0 || occupancy !== 5'd2) begin errors++; $display("FAIL wrap_rp0: got rp=%0d occ=%0d expected 0/2", read_pointer, occupancy); end
  endtask

  task automatic test_underflow();
    read_request = 1'b1;
    tick();
    tick();
    checks++; if (occupancy !== 5'd0 || underflow !== 1'b0) begin errors++; $display("FAIL uf_setup: got occ=%0d uf=%0b expected 0/0", occupancy, underflow); end
    checks++; if (read_valid !== 1'b0) begin errors++; $display("FAIL uf_valid: got %0b expected 0", read_valid); end
    tick();
    checks++; if (underflow !== 1'b1 || dut.state !== FILL) begin errors++; $display("FAIL uf_set: got uf=%0b state=%0d expected 1/%0d", underflow, dut.state, FILL); end
    checks++; if (read_pointer !== 5'd2) begin errors++; $display("FAIL uf_rp_hold: got %0d expected 2", read_pointer); end
    read_request = 1'b0;
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %0b expected 0", underflow); end
  endtask

  task automatic test_overflow();
    // rp=2; write jumps to rp+16 while clear is held: set must win
    write_pointer_sync = 5'd18;
    clear_errors = 1'b1;
    #1;
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL of_occ: got %0d expected 16", occupancy); end
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL of_set_wins: got %0b expected 1", overflow); end
    checks++; if (read_pointer !== 5'd10 || occupancy !== 5'd8) begin errors++; $display("FAIL of_recentre: got rp=%0d occ=%0d expected 10/8", read_pointer, occupancy); end
    checks++; if (dut.state !== FILL) begin errors++; $display("FAIL of_state: got %0d expected %0d", dut.state, FILL); end
    tick();
    clear_errors = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL of_clear: got %0b expected 0", overflow); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    write_pointer_sync = '0;
    read_request = 1'b0;
    read_data_is_skp = 1'b0;
    clear_errors = 1'b0;
    test_reset();
    test_fill_to_run();
    test_delete();
    test_insert();
    test_wrap();
    test_underflow();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_elastic_buffer_controller

// File: doc/elastic_buffer_controller.md
ELASTIC_BUFFER_CONTROLLER -- requirements
Module: elastic_buffer_controller

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, buffer depth DEPTH = 2**ADDRESS_WIDTH.
REQ-002 SHALL have parameter HIGH_THRESHOLD, default 12, occupancy above which a SKP is deleted.
REQ-003 SHALL have parameter LOW_THRESHOLD, default 4, occupancy below which a SKP is inserted.
REQ-004 SHALL have parameter COMP_GAP, default 8, minimum cycles between two compensation events.
REQ-005 clock  input  1  single clock (read domain); all logic on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 write_pointer_sync  input  ADDRESS_WIDTH+1  binary write pointer, already synchronized into this domain.
REQ-008 read_request  input  1  downstream requests one symbol this cycle.
REQ-009 read_data_is_skp  input  1  symbol at current read_pointer is a SKP symbol (combinational memory read).
REQ-010 clear_errors  input  1  clears sticky error flags.
REQ-011 read_pointer  output  ADDRESS_WIDTH+1  binary read pointer (memory address = low ADDRESS_WIDTH bits; MSB is wrap bit).
REQ-012 read_valid  output  1  symbol at read_pointer is delivered this cycle.
REQ-013 skp_inserted / skp_deleted  output  1 each  single-cycle compensation pulses.
REQ-014 occupancy  output  ADDRESS_WIDTH+1  current fill level, 0..DEPTH.
REQ-015 underflow / overflow  output  1 each  sticky error flags.

Function
REQ-016 occupancy SHALL equal (write_pointer_sync - read_pointer) modulo 2**(ADDRESS_WIDTH+1), combinational.
REQ-017 FSM states SHALL be FILL, RUN, INSERT_HOLD.
REQ-018 FILL: read_valid=0, read_pointer held; transition to RUN when occupancy >= DEPTH/2.
REQ-019 RUN, read_request=0: no pointer change, read_valid=0, gap counter still advances.
REQ-020 RUN, read_request=1, normal: read_valid=1 same cycle, read_pointer+1 at next edge (wraps modulo 2**(ADDRESS_WIDTH+1)).
REQ-021 Delete: RUN, read_request=1, read_data_is_skp=1, occupancy > HIGH_THRESHOLD, gap counter >= COMP_GAP -> read_valid=0, read_pointer+1, skp_deleted=1, gap counter cleared.
REQ-022 Insert: RUN, read_request=1, read_data_is_skp=1, occupancy < LOW_THRESHOLD, occupancy >= 1, gap counter >= COMP_GAP -> read_valid=1, read_pointer held, skp_inserted=1, gap counter cleared, go to INSERT_HOLD.
REQ-023 INSERT_HOLD: behaves as RUN normal read (no compensation allowed), returns to RUN after the first accepted read_request.
REQ-024 Underflow: read_request=1 with occupancy=0 in RUN/INSERT_HOLD -> read_valid=0, underflow set, state -> FILL.
REQ-025 Overflow: occupancy = DEPTH in any state -> overflow set, read_pointer jumps to write_pointer_sync - DEPTH/2 at next edge, state -> FILL.
REQ-026 Simultaneous error and clear_errors: set wins.
REQ-027 Gap counter SHALL saturate at COMP_GAP; width clog2(COMP_GAP)+1.
REQ-028 Delete and insert conditions are mutually exclusive by thresholds; LOW_THRESHOLD < DEPTH/2 < HIGH_THRESHOLD required, checked by elaboration assertion.

Reset
REQ-029 On reset low: state=FILL, read_pointer=0, gap counter=COMP_GAP (compensation allowed immediately), underflow=0, overflow=0.
REQ-030 Combinational outputs during reset: read_valid=0, skp_inserted=0, skp_deleted=0; occupancy tracks write_pointer_sync.
REQ-031 Reset asserted mid-operation SHALL abort any INSERT_HOLD and discard pending compensation.

Structure
REQ-032 Package elastic_buffer_pkg SHALL hold the FSM state enum and default threshold/gap constants.
REQ-033 No sub-module; the gray-code pointer synchronizer is instantiated beside this block at the elastic-buffer top, not inside it.

Verification (ADDRESS_WIDTH=4, defaults)
REQ-034 Reset, write_pointer_sync stepped 0->8 -> read_valid stays 0 until occupancy=8, then RUN; read_request=1 gives read_valid=1, read_pointer 0->1.
REQ-035 Occupancy 13, SKP at head, gap satisfied -> skp_deleted pulse, read_valid=0, read_pointer+1; second SKP within 8 cycles -> no deletion.
REQ-036 Occupancy 3, SKP at head -> skp_inserted pulse, read_valid=1, read_pointer held one cycle, then advances; no second insert on same SKP.
REQ-037 read_pointer 31, read_request=1 -> read_pointer=0; occupancy correct across wrap (write 2, read 30 -> 4).
REQ-038 Drain to occupancy 0 with read_request=1 -> underflow=1, state FILL; clear_errors -> underflow=0; write pointer reaching read+16 -> overflow=1, read_pointer = write-8.
